// File: rtl/mips_multicycle_core_if.sv
// mips_multicycle_core_if: shared instruction/data memory bus with req/ready handshake
interface mips_multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-subset core sharing one ALU and one memory port
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          NUM_REGS        = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  mips_multicycle_core_if.master mem,
  output logic [31:0]            PC_out,
  output logic [31:0]            ULA_out,
  output logic                   instr_retired,
  output logic                   halted
);
  localparam int RW = $clog2(NUM_REGS);
  localparam logic [RW-1:0] RA = '1;
  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_out_q, mdr_q;
  logic [31:0] regs_q [NUM_REGS];
  logic [5:0] op, funct;
  logic [RW-1:0] rs, rt, rd, dest;
  logic is_r, r_add, r_sub, r_and, r_or, r_slt, r_jr;
  logic is_addi, is_slti, is_andi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic is_r_alu, is_i_alu, is_ctl, illegal, taken;
  logic [31:0] imm_s, imm_z, opb, alu_res, jtarget;
  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs       = ir_q[21 +: RW];
  assign rt       = ir_q[16 +: RW];
  assign rd       = ir_q[11 +: RW];
  assign is_r     = op == 6'h00;
  assign r_add    = is_r && funct == 6'h20;
  assign r_sub    = is_r && funct == 6'h22;
  assign r_and    = is_r && funct == 6'h24;
  assign r_or     = is_r && funct == 6'h25;
  assign r_slt    = is_r && funct == 6'h2A;
  assign r_jr     = is_r && funct == 6'h08;
  assign is_j     = op == 6'h02;
  assign is_jal   = op == 6'h03;
  assign is_beq   = op == 6'h04;
  assign is_bne   = op == 6'h05;
  assign is_addi  = op == 6'h08;
  assign is_slti  = op == 6'h0A;
  assign is_andi  = op == 6'h0C;
  assign is_ori   = op == 6'h0D;
  assign is_lw    = op == 6'h23;
  assign is_sw    = op == 6'h2B;
  assign is_r_alu = r_add | r_sub | r_and | r_or | r_slt;
  assign is_i_alu = is_addi | is_slti | is_andi | is_ori;
  assign is_ctl   = is_beq | is_bne | is_j | is_jal | r_jr;
  assign illegal  = !(is_r_alu | is_i_alu | is_lw | is_sw | is_ctl);
  assign dest     = is_r ? rd : rt;
  assign imm_s    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_z    = {16'h0000, ir_q[15:0]};
  assign opb      = is_r ? b_q : (is_andi | is_ori) ? imm_z : imm_s;
  assign alu_res  = r_sub ? a_q - opb :
                    (r_and | is_andi) ? a_q & opb :
                    (r_or | is_ori) ? a_q | opb :
                    (r_slt | is_slti) ? {31'd0, $signed(a_q) < $signed(opb)} :
                    a_q + opb;
  assign taken    = (is_beq && a_q == b_q) || (is_bne && a_q != b_q);
  assign jtarget  = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign PC_out   = pc_q;
  assign ULA_out  = alu_out_q;
  // State register
  always_ff @(posedge clock) state_q <= !reset ? S_RST : state_d;
  // Next-state logic; fetch and memory states wait for the ready handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = mem.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (is_r_alu | is_i_alu) ? S_WB : (is_lw | is_sw) ? S_MEM :
                          (illegal && HALT_ON_ILLEGAL) ? S_HALT : S_FETCH;
      S_MEM:    state_d = !mem.mem_ready ? S_MEM : is_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end
  // Bus and status outputs decoded from the current state
  always_comb begin
    mem.mem_req   = state_q == S_FETCH || state_q == S_MEM;
    mem.mem_we    = state_q == S_MEM && is_sw;
    mem.mem_addr  = state_q == S_FETCH ? {pc_q[31:2], 2'b00} :
                    state_q == S_MEM ? {alu_out_q[31:2], 2'b00} : 32'd0;
    mem.mem_wdata = b_q;
    instr_retired = (state_q == S_EXEC && (is_ctl || (illegal && !HALT_ON_ILLEGAL))) ||
                    (state_q == S_MEM && mem.mem_ready && is_sw) || state_q == S_WB;
    halted        = state_q == S_HALT;
  end
  // Datapath registers: PC, IR, operand latches, ALUOut and MDR
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else if (state_q == S_FETCH) begin
      if (mem.mem_ready) begin
        ir_q <= mem.mem_rdata;
        pc_q <= pc_q + 32'd4;
      end
    end else if (state_q == S_DECODE) begin
      a_q <= rs == '0 ? 32'd0 : regs_q[rs];
      b_q <= rt == '0 ? 32'd0 : regs_q[rt];
    end else if (state_q == S_EXEC) begin
      if (is_r_alu | is_i_alu | is_lw | is_sw) alu_out_q <= alu_res;
      if (taken) pc_q <= pc_q + {imm_s[29:0], 2'b00};
      else if (is_j | is_jal) pc_q <= jtarget;
      else if (r_jr) pc_q <= a_q;
    end else if (state_q == S_MEM) begin
      if (mem.mem_ready && !is_sw) mdr_q <= mem.mem_rdata;
    end
  end
  // Register file writes: jal link in EXEC, result writeback in WB; R0 never written
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (state_q == S_EXEC && is_jal) begin
      regs_q[RA] <= pc_q;
    end else if (state_q == S_WB && dest != '0) begin
      regs_q[dest] <= is_lw ? mdr_q : alu_out_q;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed program runs on two core instances with a wait-state memory model
module tb_mips_multicycle_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0 = 1'b0, rst1 = 1'b0, hold1 = 1'b0;
  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];
  logic [1:0] wcnt = 2'd0;
  int n_assert = 0, n_fail = 0;
  logic [31:0] pc0, ula0, pc1, ula1;
  logic ret0, halt0, ret1, halt1;
  logic pv_req = 1'b0, pv_rdy = 1'b1, pv_we = 1'b0;
  logic [31:0] pv_addr = 32'd0;
  logic r_we;
  logic [31:0] r_addr, r_wdata;
  mips_multicycle_core_if bus0 ();
  mips_multicycle_core_if bus1 ();
  mips_multicycle_core #(.HALT_ON_ILLEGAL(1'b1)) dut0 (
    .clock(clk), .reset(rst0), .mem(bus0), .PC_out(pc0), .ULA_out(ula0),
    .instr_retired(ret0), .halted(halt0));
  mips_multicycle_core #(.NUM_REGS(16), .HALT_ON_ILLEGAL(1'b0)) dut1 (
    .clock(clk), .reset(rst1), .mem(bus1), .PC_out(pc1), .ULA_out(ula1),
    .instr_retired(ret1), .halted(halt1));
  // Data region (>= 0x200) of memory 0 inserts two wait cycles per request
  assign bus0.mem_rdata = mem0[bus0.mem_addr[11:2]];
  assign bus0.mem_ready = bus0.mem_req && (bus0.mem_addr < 32'h200 || wcnt == 2'd2);
  always @(posedge clk)
    wcnt <= (bus0.mem_req && bus0.mem_addr >= 32'h200 && !bus0.mem_ready) ? wcnt + 2'd1 : 2'd0;
  assign bus1.mem_rdata = mem1[bus1.mem_addr[11:2]];
  assign bus1.mem_ready = bus1.mem_req && !(hold1 && bus1.mem_addr >= 32'h200);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  task automatic step(input bit sel, input string tag, input int lat, input logic [31:0] next_pc);
    int n;
    logic req, rdy, we, ret;
    logic [31:0] addr, wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      req  = sel ? bus1.mem_req : bus0.mem_req;
      rdy  = sel ? bus1.mem_ready : bus0.mem_ready;
      we   = sel ? bus1.mem_we : bus0.mem_we;
      addr = sel ? bus1.mem_addr : bus0.mem_addr;
      wd   = sel ? bus1.mem_wdata : bus0.mem_wdata;
      ret  = sel ? ret1 : ret0;
      if (pv_req && !pv_rdy) begin
        chk({tag, "_held_req"}, {31'd0, req}, 32'd1);
        chk({tag, "_held_addr"}, addr, pv_addr);
        chk({tag, "_held_we"}, {31'd0, we}, {31'd0, pv_we});
      end
      pv_req = req; pv_rdy = rdy; pv_we = we; pv_addr = addr;
    end while (!ret && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    r_we = we; r_addr = addr; r_wdata = wd;
    if (ret && we && rdy) begin
      if (sel) mem1[addr[11:2]] = wd;
      else mem0[addr[11:2]] = wd;
    end
    @(posedge clk);
    #1;
    chk({tag, "_next_pc"}, sel ? pc1 : pc0, next_pc);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'd0;
      mem1[i] = 32'd0;
    end
    mem0[0]  = 32'h2001_0005;
    mem0[1]  = 32'h2002_FFFD;
    mem0[2]  = 32'h0022_1820;
    mem0[3]  = 32'h0041_202A;
    mem0[4]  = 32'h1021_0002;
    mem0[5]  = 32'hFC00_0000;
    mem0[6]  = 32'hFC00_0000;
    mem0[7]  = 32'h1421_0005;
    mem0[8]  = 32'h0C00_0040;
    mem0[9]  = 32'hAC09_0214;
    mem0[10] = 32'hFC00_0000;
    mem0[64] = 32'h2000_0007;
    mem0[65] = 32'hAC03_0200;
    mem0[66] = 32'h8C05_0200;
    mem0[67] = 32'hAC05_0204;
    mem0[68] = 32'hAC00_0208;
    mem0[69] = 32'hAC1F_020C;
    mem0[70] = 32'h3046_FF00;
    mem0[71] = 32'h3407_8001;
    mem0[72] = 32'h2848_FFFE;
    mem0[73] = 32'h0022_4822;
    mem0[74] = 32'h0022_5025;
    mem0[75] = 32'hAC04_0210;
    mem0[76] = 32'h03E0_0008;
    mem1[0]   = 32'hAC02_0204;
    mem1[1]   = 32'h2001_0009;
    mem1[2]   = 32'hFC00_0000;
    mem1[3]   = 32'h8C02_0200;
    mem1[128] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc0, 32'd0);
    chk("rst_ula", ula0, 32'd0);
    chk("rst_req", {31'd0, bus0.mem_req}, 32'd0);
    chk("rst_we", {31'd0, bus0.mem_we}, 32'd0);
    chk("rst_addr", bus0.mem_addr, 32'd0);
    chk("rst_retired", {31'd0, ret0}, 32'd0);
    chk("rst_halted", {31'd0, halt0}, 32'd0);
    rst0 = 1'b1;
    #6;
    chk("boot_req", {31'd0, bus0.mem_req}, 32'd1);
    chk("boot_addr", bus0.mem_addr, 32'd0);
    chk("boot_we", {31'd0, bus0.mem_we}, 32'd0);
    step(0, "addi1", 4, 32'h04);   chk("addi1_ula", ula0, 32'd5);
    step(0, "addi2", 4, 32'h08);   chk("addi2_ula", ula0, 32'hFFFF_FFFD);
    step(0, "add", 4, 32'h0C);     chk("add_ula", ula0, 32'd2);
    step(0, "slt", 4, 32'h10);     chk("slt_ula", ula0, 32'd1);
    step(0, "beq", 3, 32'h1C);
    step(0, "bne", 3, 32'h20);
    step(0, "jal", 3, 32'h100);
    step(0, "addi_r0", 4, 32'h104); chk("addi_r0_ula", ula0, 32'd7);
    step(0, "sw3", 6, 32'h108);
    chk("sw3_we", {31'd0, r_we}, 32'd1);
    chk("sw3_addr", r_addr, 32'h200);
    chk("sw3_wdata", r_wdata, 32'd2);
    step(0, "lw5", 7, 32'h10C);    chk("lw5_ula", ula0, 32'h200);
    step(0, "sw5", 6, 32'h110);
    chk("sw5_addr", r_addr, 32'h204);
    chk("sw5_wdata", r_wdata, 32'd2);
    step(0, "sw0", 6, 32'h114);    chk("sw0_wdata", r_wdata, 32'd0);
    step(0, "sw31", 6, 32'h118);   chk("sw31_wdata", r_wdata, 32'h24);
    step(0, "andi", 4, 32'h11C);   chk("andi_ula", ula0, 32'h0000_FF00);
    step(0, "ori", 4, 32'h120);    chk("ori_ula", ula0, 32'h0000_8001);
    step(0, "slti", 4, 32'h124);   chk("slti_ula", ula0, 32'd1);
    step(0, "sub", 4, 32'h128);    chk("sub_ula", ula0, 32'd8);
    step(0, "or", 4, 32'h12C);     chk("or_ula", ula0, 32'hFFFF_FFFD);
    step(0, "sw4", 6, 32'h130);    chk("sw4_wdata", r_wdata, 32'd1);
    step(0, "jr", 3, 32'h24);
    step(0, "sw9", 6, 32'h28);
    chk("sw9_addr", r_addr, 32'h214);
    chk("sw9_wdata", r_wdata, 32'd8);
    repeat (3) @(negedge clk);
    chk("ill_no_retire", {31'd0, ret0}, 32'd0);
    @(negedge clk);
    chk("halt_flag", {31'd0, halt0}, 32'd1);
    chk("halt_req", {31'd0, bus0.mem_req}, 32'd0);
    repeat (5) @(negedge clk);
    chk("halt_hold_flag", {31'd0, halt0}, 32'd1);
    chk("halt_hold_req", {31'd0, bus0.mem_req}, 32'd0);
    chk("halt_hold_retired", {31'd0, ret0}, 32'd0);
    chk("halt_hold_pc", pc0, 32'h2C);
    rst1 = 1'b1;
    step(1, "b_sw2", 4, 32'h04);
    chk("b_sw2_addr", r_addr, 32'h204);
    chk("b_sw2_wdata", r_wdata, 32'd0);
    step(1, "b_addi", 4, 32'h08);  chk("b_addi_ula", ula1, 32'd9);
    step(1, "b_illegal", 3, 32'h0C);
    chk("b_illegal_halted", {31'd0, halt1}, 32'd0);
    hold1 = 1'b1;
    repeat (5) @(negedge clk);
    chk("b_stall_req", {31'd0, bus1.mem_req}, 32'd1);
    chk("b_stall_addr", bus1.mem_addr, 32'h200);
    chk("b_stall_we", {31'd0, bus1.mem_we}, 32'd0);
    chk("b_stall_retired", {31'd0, ret1}, 32'd0);
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    chk("b_abort_req", {31'd0, bus1.mem_req}, 32'd0);
    chk("b_abort_pc", pc1, 32'd0);
    chk("b_abort_ula", ula1, 32'd0);
    @(negedge clk);
    rst1 = 1'b1;
    hold1 = 1'b0;
    step(1, "b_sw2_again", 4, 32'h04);
    chk("b_sw2_again_wdata", r_wdata, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
